// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants, register map and FSM state type for the SPART
package spart_pkg;

    localparam logic [1:0]  ADDR_DATA   = 2'b00;
    localparam logic [1:0]  ADDR_STATUS = 2'b01;
    localparam logic [1:0]  ADDR_DBL    = 2'b10;
    localparam logic [1:0]  ADDR_DBH    = 2'b11;

    // 9600 baud from 50 MHz with 16x oversampling
    localparam logic [15:0] DIV_RESET_DEFAULT = 16'd325;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// rtl/spart_baud_gen.sv - 16-bit reloading down-counter producing the 16x oversample enable
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = DIV_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor_i,
    output logic        baud_en_o
);

    logic [15:0] cnt_q, cnt_d;

    // A new divisor is only picked up at reload, so the current period always completes.
    always_comb begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd0) begin
            cnt_d = divisor_i;
        end
    end

    assign baud_en_o = (cnt_q == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= DIV_RESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spart.sv
// rtl/spart.sv - SPART UART core (8N1, full duplex); SPART_STATUS_EN makes status readable at 01
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = DIV_RESET_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic       baud_en, wr, rd;
    logic [7:0] dbl_q, dbh_q, rdata;
    state_e     tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [3:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_buf_q, rx_buf_d;
    logic       tbr_q, tbr_d, rda_q, rda_d;
    logic       rx_sync1_q, rx_sync2_q, rx_prev_q;

    assign wr = iocs & ~iorw;
    assign rd = iocs & iorw;

    spart_baud_gen #(.DIV_RESET(DIV_RESET)) u_baud (
        .clk       (clk),
        .rst       (rst),
        .divisor_i ({dbh_q, dbl_q}),
        .baud_en_o (baud_en)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tbr_d      = tbr_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (wr && ioaddr == ADDR_DATA && tbr_q) begin
                    tx_shift_d = databus;
                    tbr_d      = 1'b0;
                end else if (!tbr_q && baud_en) begin
                    tx_state_d = ST_START;
                    tx_cnt_d   = 4'd0;
                end
            end
            ST_START: if (baud_en) begin
                tx_cnt_d = tx_cnt_q + 4'd1;
                if (tx_cnt_q == 4'd15) begin
                    tx_state_d = ST_DATA;
                    tx_bit_d   = 3'd0;
                end
            end
            ST_DATA: if (baud_en) begin
                tx_cnt_d = tx_cnt_q + 4'd1;
                if (tx_cnt_q == 4'd15) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                end
            end
            ST_STOP: if (baud_en) begin
                tx_cnt_d = tx_cnt_q + 4'd1;
                if (tx_cnt_q == 4'd15) begin
                    tx_state_d = ST_IDLE;
                    tbr_d      = 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (tx_state_q)
            ST_START: txd = 1'b0;
            ST_DATA:  txd = tx_shift_q[0];
            default:  txd = 1'b1;
        endcase
    end

    // A completing byte overrides a same-edge read clear, so rda never drops a fresh byte.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_buf_d   = rx_buf_q;
        rda_d      = rda_q;
        if (rd && ioaddr == ADDR_DATA) rda_d = 1'b0;
        case (rx_state_q)
            ST_IDLE: if (rx_prev_q && !rx_sync2_q) begin
                rx_state_d = ST_START;
                rx_cnt_d   = 4'd0;
            end
            ST_START: if (baud_en) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd7) begin
                    if (rx_sync2_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_cnt_d   = 4'd0;
                        rx_bit_d   = 3'd0;
                    end
                end
            end
            ST_DATA: if (baud_en) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd15) begin
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                end
            end
            ST_STOP: if (baud_en) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd15) begin
                    rx_state_d = ST_IDLE;
                    if (rx_sync2_q) begin
                        rx_buf_d = rx_shift_q;
                        rda_d    = 1'b1;
                    end
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbl_q      <= DIV_RESET[7:0];
            dbh_q      <= DIV_RESET[15:8];
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tbr_q      <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_buf_q   <= 8'h00;
            rda_q      <= 1'b0;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            if (wr && ioaddr == ADDR_DBL) dbl_q <= databus;
            if (wr && ioaddr == ADDR_DBH) dbh_q <= databus;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tbr_q      <= tbr_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_buf_q   <= rx_buf_d;
            rda_q      <= rda_d;
            rx_sync1_q <= rxd;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (ioaddr)
            ADDR_DATA:   rdata = rx_buf_q;
`ifdef SPART_STATUS_EN
            ADDR_STATUS: rdata = {6'b0, rda_q, tbr_q};
`else
            ADDR_STATUS: rdata = 8'h00;
`endif
            ADDR_DBL:    rdata = dbl_q;
            ADDR_DBH:    rdata = dbh_q;
            default:     rdata = 8'h00;
        endcase
    end

    assign databus = rd ? rdata : 8'hzz;
    assign rda     = rda_q;
    assign tbr     = tbr_q;

endmodule

// File: tb/tb_spart.sv
// tb/tb_spart.sv - directed bench for two cross-connected SPART instances
module tb_spart;

`ifdef SPART_STATUS_EN
    localparam logic [7:0] ST_TBR     = 8'h01;
    localparam logic [7:0] ST_TBR_RDA = 8'h03;
`else
    localparam logic [7:0] ST_TBR     = 8'h00;
    localparam logic [7:0] ST_TBR_RDA = 8'h00;
`endif
    localparam int BIT_FAST = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs_a = 1'b0, rw_a = 1'b0, drv_a = 1'b0;
    logic cs_b = 1'b0, rw_b = 1'b0, drv_b = 1'b0;
    logic [1:0] ad_a = 2'b00, ad_b = 2'b00;
    logic [7:0] wd_a = 8'h00, wd_b = 8'h00;
    logic rx_ovr = 1'b0, tb_rxd = 1'b1;
    wire  [7:0] bus_a, bus_b;
    wire  rda_a, tbr_a, txd_a, rda_b, tbr_b, txd_b, rxd_a;
    int   total = 0;
    int   bad = 0;

    assign bus_a = drv_a ? wd_a : 8'hzz;
    assign bus_b = drv_b ? wd_b : 8'hzz;
    assign rxd_a = rx_ovr ? tb_rxd : txd_b;

    always #5 clk = ~clk;

    spart u_a (.clk(clk), .rst(rst), .iocs(cs_a), .iorw(rw_a), .ioaddr(ad_a), .databus(bus_a),
               .rda(rda_a), .tbr(tbr_a), .txd(txd_a), .rxd(rxd_a));
    spart u_b (.clk(clk), .rst(rst), .iocs(cs_b), .iorw(rw_b), .ioaddr(ad_b), .databus(bus_b),
               .rda(rda_b), .tbr(tbr_b), .txd(txd_b), .rxd(txd_a));

    task automatic bus_wr(input bit b, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        if (b) begin cs_b = 1'b1; rw_b = 1'b0; ad_b = a; wd_b = d; drv_b = 1'b1; end
        else   begin cs_a = 1'b1; rw_a = 1'b0; ad_a = a; wd_a = d; drv_a = 1'b1; end
        @(negedge clk);
        cs_a = 1'b0; drv_a = 1'b0; cs_b = 1'b0; drv_b = 1'b0;
    endtask

    task automatic bus_rd(input bit b, input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        if (b) begin cs_b = 1'b1; rw_b = 1'b1; ad_b = a; end
        else   begin cs_a = 1'b1; rw_a = 1'b1; ad_a = a; end
        #1;
        d = b ? bus_b : bus_a;
        @(negedge clk);
        cs_a = 1'b0; cs_b = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        tb_rxd = 1'b0;
        repeat (BIT_FAST) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            tb_rxd = d[i];
            repeat (BIT_FAST) @(posedge clk);
        end
        tb_rxd = stop;
        repeat (BIT_FAST) @(posedge clk);
        tb_rxd = 1'b1;
        repeat (BIT_FAST) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_rd(0, 2'b01, d);
        total++; if (d !== ST_TBR) begin $display("FAIL reset_status got=%h exp=%h", d, ST_TBR); bad++; end
        total++; if (txd_a !== 1'b1) begin $display("FAIL reset_txd got=%b exp=1", txd_a); bad++; end
        total++; if (tbr_a !== 1'b1) begin $display("FAIL reset_tbr got=%b exp=1", tbr_a); bad++; end
        total++; if (rda_a !== 1'b0) begin $display("FAIL reset_rda got=%b exp=0", rda_a); bad++; end
        bus_rd(0, 2'b10, d);
        total++; if (d !== 8'h45) begin $display("FAIL reset_dbl got=%h exp=45", d); bad++; end
        bus_rd(0, 2'b11, d);
        total++; if (d !== 8'h01) begin $display("FAIL reset_dbh got=%h exp=01", d); bad++; end
        bus_rd(0, 2'b00, d);
        total++; if (d !== 8'h00) begin $display("FAIL reset_rxbuf got=%h exp=00", d); bad++; end
        @(negedge clk);
        ad_a = 2'b10; rw_a = 1'b1; cs_a = 1'b0; wd_a = 8'h5A; drv_a = 1'b1;
        #1;
        total++; if (bus_a !== 8'h5A) begin $display("FAIL bus_release got=%h exp=5a", bus_a); bad++; end
        @(negedge clk);
        drv_a = 1'b0; rw_a = 1'b0;
    endtask

    task automatic test_tx_frame();
        logic [7:0] d;
        logic [7:0] tx_byte;
        int n;
        tx_byte = 8'h48;
        bus_wr(0, 2'b10, 8'h45);
        bus_wr(0, 2'b11, 8'h01);
        bus_wr(0, 2'b00, tx_byte);
        total++; if (tbr_a !== 1'b0) begin $display("FAIL tx_tbr_low got=%b exp=0", tbr_a); bad++; end
        n = 0;
        while (txd_a !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        total++; if (txd_a !== 1'b0) begin $display("FAIL tx_start_timeout got=%b exp=0", txd_a); bad++; end
        // start + bits 0..2 of 8'h48 are all low: 4 bit times of 326*16 clocks
        n = 0;
        while (txd_a === 1'b0 && n < 30000) begin @(negedge clk); n++; end
        total++; if (n !== 20864) begin $display("FAIL tx_low_run got=%0d exp=20864", n); bad++; end
        repeat (2608) @(negedge clk);
        for (int i = 3; i < 8; i++) begin
            total++; if (txd_a !== tx_byte[i]) begin $display("FAIL tx_bit%0d got=%b exp=%b", i, txd_a, tx_byte[i]); bad++; end
            repeat (5216) @(negedge clk);
        end
        total++; if (txd_a !== 1'b1) begin $display("FAIL tx_stop got=%b exp=1", txd_a); bad++; end
        total++; if (tbr_a !== 1'b0) begin $display("FAIL tx_tbr_in_stop got=%b exp=0", tbr_a); bad++; end
        repeat (2612) @(negedge clk);
        total++; if (tbr_a !== 1'b1) begin $display("FAIL tx_tbr_after got=%b exp=1", tbr_a); bad++; end
        total++; if (rda_b !== 1'b1) begin $display("FAIL rx_slow_rda got=%b exp=1", rda_b); bad++; end
        bus_rd(1, 2'b00, d);
        total++; if (d !== 8'h48) begin $display("FAIL rx_slow_data got=%h exp=48", d); bad++; end
        total++; if (rda_b !== 1'b0) begin $display("FAIL rx_slow_clear got=%b exp=0", rda_b); bad++; end
        bus_wr(0, 2'b10, 8'h03);
        bus_wr(0, 2'b11, 8'h00);
        bus_wr(1, 2'b10, 8'h03);
        bus_wr(1, 2'b11, 8'h00);
        repeat (800) @(negedge clk);
        bus_rd(0, 2'b10, d);
        total++; if (d !== 8'h03) begin $display("FAIL dbl_write got=%h exp=03", d); bad++; end
    endtask

    task automatic test_hello();
        logic [7:0] msg [13];
        logic [7:0] d;
        int n, pulses;
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
        pulses = 0;
        for (int k = 0; k < 13; k++) begin
            n = 0;
            while (tbr_a !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
            bus_wr(0, 2'b00, msg[k]);
            n = 0;
            while (rda_b !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
            if (rda_b === 1'b1) pulses++;
            bus_rd(1, 2'b00, d);
            total++; if (d !== msg[k]) begin $display("FAIL hello_byte%0d got=%h exp=%h", k, d, msg[k]); bad++; end
            total++; if (rda_b !== 1'b0) begin $display("FAIL hello_clear%0d got=%b exp=0", k, rda_b); bad++; end
        end
        total++; if (pulses !== 13) begin $display("FAIL hello_pulses got=%0d exp=13", pulses); bad++; end
    endtask

    task automatic test_glitch_framing();
        rx_ovr = 1'b1;
        tb_rxd = 1'b1;
        repeat (100) @(posedge clk);
        tb_rxd = 1'b0;
        repeat (12) @(posedge clk);
        tb_rxd = 1'b1;
        repeat (800) @(negedge clk);
        total++; if (rda_a !== 1'b0) begin $display("FAIL glitch_rda got=%b exp=0", rda_a); bad++; end
        send_rx(8'h55, 1'b0);
        repeat (64) @(negedge clk);
        total++; if (rda_a !== 1'b0) begin $display("FAIL framing_rda got=%b exp=0", rda_a); bad++; end
    endtask

    task automatic test_overwrite();
        logic [7:0] d;
        send_rx(8'hA5, 1'b1);
        @(negedge clk);
        total++; if (rda_a !== 1'b1) begin $display("FAIL ovw_first_rda got=%b exp=1", rda_a); bad++; end
        send_rx(8'h3C, 1'b1);
        @(negedge clk);
        total++; if (rda_a !== 1'b1) begin $display("FAIL ovw_second_rda got=%b exp=1", rda_a); bad++; end
        bus_rd(0, 2'b01, d);
        total++; if (d !== ST_TBR_RDA) begin $display("FAIL ovw_status got=%h exp=%h", d, ST_TBR_RDA); bad++; end
        bus_rd(0, 2'b00, d);
        total++; if (d !== 8'h3C) begin $display("FAIL ovw_data got=%h exp=3c", d); bad++; end
        total++; if (rda_a !== 1'b0) begin $display("FAIL ovw_clear got=%b exp=0", rda_a); bad++; end
    endtask

    task automatic test_tx_busy();
        logic [7:0] d;
        int n;
        bus_wr(0, 2'b00, 8'h5A);
        bus_wr(0, 2'b00, 8'hC3);
        total++; if (tbr_a !== 1'b0) begin $display("FAIL busy_tbr got=%b exp=0", tbr_a); bad++; end
        n = 0;
        while (rda_b !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        total++; if (rda_b !== 1'b1) begin $display("FAIL busy_rx_timeout got=%b exp=1", rda_b); bad++; end
        bus_rd(1, 2'b00, d);
        total++; if (d !== 8'h5A) begin $display("FAIL busy_data got=%h exp=5a", d); bad++; end
        repeat (1000) @(negedge clk);
        total++; if (rda_b !== 1'b0) begin $display("FAIL busy_no_second got=%b exp=0", rda_b); bad++; end
        total++; if (tbr_a !== 1'b1) begin $display("FAIL busy_tbr_idle got=%b exp=1", tbr_a); bad++; end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        bus_wr(0, 2'b00, 8'h00);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (txd_a !== 1'b1) begin $display("FAIL midrst_txd got=%b exp=1", txd_a); bad++; end
        total++; if (tbr_a !== 1'b1) begin $display("FAIL midrst_tbr got=%b exp=1", tbr_a); bad++; end
        bus_rd(1, 2'b10, d);
        total++; if (d !== 8'h45) begin $display("FAIL midrst_dbl got=%h exp=45", d); bad++; end
        repeat (1500) @(negedge clk);
        total++; if (rda_b !== 1'b0) begin $display("FAIL midrst_rda got=%b exp=0", rda_b); bad++; end
        bus_rd(1, 2'b00, d);
        total++; if (d !== 8'h00) begin $display("FAIL midrst_rxbuf got=%h exp=00", d); bad++; end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_hello();
        test_glitch_framing();
        test_overwrite();
        rx_ovr = 1'b0;
        test_tx_busy();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/spart.md
SPART -- requirements
Module: spart

Interface
REQ-001 Parameter DIV_RESET, default 16'd325, divisor loaded at reset (9600 baud at 50 MHz, 16x oversampling).
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 iocs  input  1  chip select; an access occurs on every clk edge where iocs=1.
REQ-005 iorw  input  1  1=read, 0=write.
REQ-006 ioaddr  input  2  register select: 00 data (TX write / RX read), 01 status, 10 divisor low byte (DBL), 11 divisor high byte (DBH).
REQ-007 databus  inout  8  bidirectional bus; driven only when iocs=1 and iorw=1, else high-Z.
REQ-008 rda  output  1  receive data available.
REQ-009 tbr  output  1  transmit buffer ready.
REQ-010 txd  output  1  serial out; idle 1.
REQ-011 rxd  input  1  serial in; asynchronous to clk.

Function
REQ-012 Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-013 Baud generator: 16-bit down-counter reloads with {DBH,DBL} on reaching 0 and emits a 1-cycle enable; enable period = divisor+1 clocks; one bit time = 16 enables.
REQ-014 Divisor write to 10/11 updates that byte on the access edge; the new value takes effect at the next counter reload.
REQ-015 Read data is combinational: addr 00 returns RX buffer, addr 01 returns {6'b0, rda, tbr}, addr 10/11 return DBL/DBH.
REQ-016 Write to 00 with tbr=1: byte loaded into TX shift register and tbr deasserted on the same edge; start bit begins on the next baud enable.
REQ-017 Write to 00 with tbr=0 is ignored; write to 01 is ignored.
REQ-018 TX states IDLE, START, DATA, STOP; each state holds 16 enables; tbr reasserts on the edge ending STOP.
REQ-019 rxd passes through a 2-flop synchronizer, reset to 1, before any use.
REQ-020 RX states IDLE, START, DATA, STOP: 1->0 edge in IDLE enters START; after 8 enables rxd is re-checked; if 1 the start is false and RX returns to IDLE.
REQ-021 DATA samples every 16 enables (mid-bit), 8 bits; STOP samples once more.
REQ-022 Stop=1: byte written to RX buffer and rda set; stop=0 (framing error): byte discarded, rda unchanged.
REQ-023 Read of addr 00 clears rda on the access edge.
REQ-024 Completed byte arriving while rda=1 overwrites the buffer; rda stays 1.
REQ-025 Byte completion on the same edge as an addr-00 read: the new byte is stored and rda stays 1.
REQ-026 TX and RX operate independently and full-duplex.

Reset
REQ-027 On rst: txd=1, tbr=1, rda=0, RX buffer=8'h00, divisor=DIV_RESET, baud counter=DIV_RESET, both FSMs in IDLE, synchronizer=1, databus high-Z.
REQ-028 rst asserted mid-frame aborts the frame; no partial byte is delivered.

Configuration
REQ-029 Macro SPART_STATUS_EN defined: status register readable at 01 per REQ-015.
REQ-030 Macro SPART_STATUS_EN undefined: reads of 01 return 8'h00; rda/tbr pins are unaffected.

Structure
REQ-031 Package spart_pkg holds the ioaddr constants, FSM state enum, and DIV_RESET default.
REQ-032 The baud generator is sub-module spart_baud_gen (divisor in, enable out); TX/RX stay in spart.

Verification
REQ-033 Reset, then read 01 -> 8'h01 (tbr=1, rda=0); txd=1; databus Z when iocs=0.
REQ-034 Write DBL=8'h45, DBH=8'h01, write 00=8'h48 -> txd shows 0,00010010,1 with each bit 326*16 clocks; tbr low until stop ends.
REQ-035 Two spart instances cross-connected, both at divisor 325; send "Hello, World!" one byte per tbr -> receiver rda pulses 13 times, reads return same bytes in order, rda cleared after each read.
REQ-036 Drive a 3-enable low glitch on rxd -> no byte, rda stays 0; drive a frame with stop=0 -> rda stays 0.
REQ-037 Receive 8'hA5 and then 8'h3C without reading -> rda=1, read returns 8'h3C; write 00 while tbr=0 -> byte not sent.
